// File: rtl/data_memory.sv
// data_memory: word-organised data memory for the single-cycle MIPS datapath.
// Byte-addressed and word-aligned. Stores commit on the rising clock edge and
// loads are combinational. The storage array is named `mem` so that it can be
// reached hierarchically, for example to preload or inspect it from a bench.
module data_memory #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256   // must be a power of two, >= 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           Addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  mem_read,
  input  logic                  mem_write
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [AW-1:0] index;
  logic          in_range;

  // Addr[1:0] is ignored, so misaligned addresses alias onto their word.
  // The address is in range only when every bit above the index is zero.
  assign index    = Addr[AW+1:2];
  assign in_range = (Addr[31:AW+2] == '0);

  // Asynchronous clear of the whole array; otherwise commit in-range stores.
  // Out-of-range stores are dropped silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_write && in_range) begin
      mem[index] <= write_data;
    end
  end

  // Combinational load path. It drives zero when no load is requested or the
  // address is out of range, and it does not forward pending store data.
  always_comb begin
    data_out = '0;
    if (mem_read && in_range) begin
      data_out = mem[index];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory. It uses directed scenarios followed by
// randomized traffic, and checks every result against an array-based
// reference model.
module tb_data_memory;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 256;

  logic          clk;
  logic          rst_n;
  logic [31:0]   Addr;
  logic [DW-1:0] write_data;
  logic [DW-1:0] data_out;
  logic          mem_read;
  logic          mem_write;

  int unsigned n_tests;
  int unsigned n_fail;

  logic [DW-1:0] ref_mem [DEPTH];

  data_memory #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Addr       (Addr),
    .write_data (write_data),
    .data_out   (data_out),
    .mem_read   (mem_read),
    .mem_write  (mem_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    return a < DEPTH * 4;
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [31:0] a, input logic rd);
    if (rd && addr_ok(a)) return ref_mem[a / 4];
    return '0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // Perform one store: drive the inputs at the falling edge, commit on the
  // rising edge, then update the reference model.
  task automatic do_write(input logic [31:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    Addr = a; write_data = d; mem_write = 1'b1; mem_read = 1'b0;
    @(posedge clk);
    #1;
    if (addr_ok(a)) ref_mem[a / 4] = d;
    mem_write = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [31:0] a);
    @(negedge clk);
    Addr = a; mem_read = 1'b1; mem_write = 1'b0;
    #1;
    check(tag, data_out, model_read(a, 1'b1));
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    model_clear();
    rst_n = 1'b0; Addr = 32'd4; write_data = '0; mem_read = 1'b1; mem_write = 1'b0;

    // Reset state: the array is zero, so a load returns 0.
    #12;
    check("reset_read", data_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write, then read back through the port and through the hierarchy.
    do_write(32'd16, 32'h12153524);
    do_read("wr_rd", 32'd16);
    check("wr_rd_mem4", dut.mem[4], 32'h12153524);

    // Preloaded word: the read is visible in the same cycle, and 0 when disabled.
    do_write(32'd4, 32'hA5A5A5A5);
    do_read("preload_rd", 32'd4);
    mem_read = 1'b0;
    #1;
    check("rd_disabled", data_out, 32'h0);

    // Asynchronous reset pulse between clock edges clears the array.
    @(negedge clk);
    Addr = 32'd4; mem_read = 1'b1;
    #1 rst_n = 1'b0;
    #1 check("async_clear_during", data_out, 32'h0);
    check("async_clear_mem4", dut.mem[4], 32'h0);
    #1 rst_n = 1'b1;
    model_clear();
    #1 check("async_clear_after", data_out, 32'h0);
    check("async_clear_mem1", dut.mem[1], 32'h0);

    // A misaligned address aliases onto its word.
    do_write(32'h10, 32'h0000CAFE);
    do_read("misalign_13", 32'h13);
    do_write(32'h21, 32'h0BADF00D);
    do_read("misalign_20", 32'h20);

    // Out-of-range stores are dropped, and out-of-range loads read 0.
    do_write(32'h0, 32'h5A5A0001);
    do_write(DEPTH * 4, 32'hFFFFFFFF);
    do_write(32'h8000_0000, 32'hFFFFFFFF);
    do_read("oor_rd_400", DEPTH * 4);
    do_read("oor_rd_hi", 32'h8000_0000);
    do_read("oor_mem0", 32'h0);
    do_read("last_word", DEPTH * 4 - 4);

    // Simultaneous read and write: old data before the edge, new data after it.
    do_write(32'd8, 32'h11111111);
    @(negedge clk);
    Addr = 32'd8; mem_read = 1'b1; mem_write = 1'b1; write_data = 32'h22222222;
    #1 check("rw_before", data_out, 32'h11111111);
    @(posedge clk);
    #1 check("rw_after", data_out, 32'h22222222);
    ref_mem[2] = 32'h22222222;
    mem_write = 1'b0;

    // Reset asserted during a pending store: the store is lost.
    do_write(32'd12, 32'h33333333);
    @(negedge clk);
    Addr = 32'd12; write_data = 32'h44444444; mem_write = 1'b1; mem_read = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    mem_write = 1'b0;
    model_clear();
    #1 check("reset_midwrite", data_out, 32'h0);

    // Randomized traffic checked against the model before and after each edge.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      logic [DW-1:0] d;
      logic rd, wr;
      if ($urandom_range(0, 9) == 0) a = $urandom();
      else a = $urandom_range(0, DEPTH * 4 - 1);
      if ($urandom_range(0, 3) == 0) a = a & 32'h3C;
      d  = $urandom();
      rd = 1'($urandom_range(0, 3) != 0);
      wr = 1'($urandom_range(0, 1));
      @(negedge clk);
      Addr = a; write_data = d; mem_read = rd; mem_write = wr;
      #1 check("rand_pre", data_out, model_read(a, rd));
      @(posedge clk);
      if (wr && addr_ok(a)) ref_mem[a / 4] = d;
      #1 check("rand_post", data_out, model_read(a, rd));
    end

    // Final sweep: every word must match the reference model.
    mem_write = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      Addr = 32'(i * 4); mem_read = 1'b1;
      #1 check("sweep", data_out, ref_mem[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
